// File: rtl/memory_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: opcodes, FSM encoding,
// requester IDs and the read-latency legality check.
package memory_port_arbiter_pkg;

    localparam logic [3:0] STORE      = 4'b1100;
    localparam logic [3:0] COPY_INPUT = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_MEM   = 1'b1
    } req_id_e;

    // The wait counter needs at least one cycle between enable and read data.
    function automatic bit latency_ok(input int unsigned lat);
        return lat >= 1;
    endfunction

endpackage

// File: rtl/memory_port_arbiter_arb_grant_select.sv
// Winner selection between fetch and memory-access requests; the memory stage
// wins ties unless the starvation flag hands the tie to fetch.
module arb_grant_select
    import memory_port_arbiter_pkg::*;
(
    input  logic    fetch_req,
    input  logic    mem_req,
    input  logic    starve,
    output logic    grant_valid_c,
    output req_id_e grant_id_c
);

    always_comb begin
        grant_valid_c = fetch_req | mem_req;
        grant_id_c    = REQ_MEM;
        if (fetch_req && (!mem_req || starve)) begin
            grant_id_c = REQ_FETCH;
        end
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// Single-port memory arbiter for the fetch and memory-access stages.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 20,
    parameter int unsigned LATENCY    = 2
`ifdef MEM_ARB_STARVE_GUARD_EN
    ,
    parameter int unsigned STARVE_LIMIT = 4
`endif
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fetchReq_In,
    input  logic [ADDR_WIDTH-1:0] fetchAddr_In,
    input  logic                  memReq_In,
    input  logic                  memWrite_In,
    input  logic [ADDR_WIDTH-1:0] memAddr_In,
    input  logic [DATA_WIDTH-1:0] memData_In,
    input  logic [DATA_WIDTH-1:0] memRdata_In,
    output logic                  memEnable_Out,
    output logic                  memWe_Out,
    output logic [ADDR_WIDTH-1:0] memAddr_Out,
    output logic [DATA_WIDTH-1:0] memWdata_Out,
    output logic                  fetchDone_Out,
    output logic                  memDone_Out,
    output logic [DATA_WIDTH-1:0] rdata_Out,
    output logic                  fetchStall_Out,
    output logic                  memStall_Out
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    if (!latency_ok(LATENCY)) begin : g_latency_check
        $error("memory_port_arbiter: LATENCY must be 1 or more");
    end

    arb_state_e            state, state_d;
    logic [CNT_W-1:0]      wait_cnt, wait_cnt_d;
    req_id_e               owner, owner_d;
    logic                  enable_d, we_d, fetch_done_d, mem_done_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d, rdata_d;
    logic                  starve;
    logic                  grant_valid;
    req_id_e               grant_id;

    arb_grant_select u_grant (
        .fetch_req     (fetchReq_In),
        .mem_req       (memReq_In),
        .starve        (starve),
        .grant_valid_c (grant_valid),
        .grant_id_c    (grant_id)
    );

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned STARVE_W =
        ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;

    logic [STARVE_W-1:0] starve_cnt, starve_cnt_d;

    assign starve = (starve_cnt >= STARVE_W'(STARVE_LIMIT));

    // Counts ties lost by fetch; any fetch win resets the run.
    always_comb begin
        starve_cnt_d = starve_cnt;
        if (state == ST_IDLE && grant_valid) begin
            if (grant_id == REQ_FETCH) begin
                starve_cnt_d = '0;
            end else if (fetchReq_In) begin
                starve_cnt_d = starve_cnt + STARVE_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt_d;
        end
    end
`else
    assign starve = 1'b0;
`endif

    // Next-state and next-output values; RESP never grants, so a request still
    // high during its done cycle is not serviced twice.
    always_comb begin
        state_d      = state;
        wait_cnt_d   = wait_cnt;
        owner_d      = owner;
        enable_d     = 1'b0;
        we_d         = 1'b0;
        fetch_done_d = 1'b0;
        mem_done_d   = 1'b0;
        addr_d       = memAddr_Out;
        wdata_d      = memWdata_Out;
        rdata_d      = rdata_Out;
        case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    owner_d  = grant_id;
                    enable_d = 1'b1;
                    state_d  = ST_ISSUE;
                    if (grant_id == REQ_MEM) begin
                        addr_d  = memAddr_In;
                        wdata_d = memData_In;
                        we_d    = memWrite_In;
                    end else begin
                        addr_d  = fetchAddr_In;
                    end
                end
            end
            ST_ISSUE: begin
                wait_cnt_d = CNT_W'(LATENCY - 1);
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    rdata_d      = memRdata_In;
                    fetch_done_d = (owner == REQ_FETCH);
                    mem_done_d   = (owner == REQ_MEM);
                    state_d      = ST_RESP;
                end else begin
                    wait_cnt_d   = wait_cnt - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            owner         <= REQ_FETCH;
            memEnable_Out <= 1'b0;
            memWe_Out     <= 1'b0;
            fetchDone_Out <= 1'b0;
            memDone_Out   <= 1'b0;
            memAddr_Out   <= '0;
            memWdata_Out  <= '0;
            rdata_Out     <= '0;
        end else begin
            state         <= state_d;
            wait_cnt      <= wait_cnt_d;
            owner         <= owner_d;
            memEnable_Out <= enable_d;
            memWe_Out     <= we_d;
            fetchDone_Out <= fetch_done_d;
            memDone_Out   <= mem_done_d;
            memAddr_Out   <= addr_d;
            memWdata_Out  <= wdata_d;
            rdata_Out     <= rdata_d;
        end
    end

    assign fetchStall_Out = fetchReq_In & ~fetchDone_Out;
    assign memStall_Out   = memReq_In & ~memDone_Out;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Self-checking bench for memory_port_arbiter: directed cases plus random traffic
// scored against a transaction-level timing model and a latency-modelled memory.
module tb_memory_port_arbiter;

    localparam int unsigned AW   = 16;
    localparam int unsigned DW   = 20;
    localparam int unsigned LAT  = 2;
    localparam int unsigned SLIM = 4;

    logic          clock, reset;
    logic          fetchReq_In, memReq_In, memWrite_In;
    logic [AW-1:0] fetchAddr_In, memAddr_In;
    logic [DW-1:0] memData_In, memRdata_In;
    logic          memEnable_Out, memWe_Out, fetchDone_Out, memDone_Out;
    logic [AW-1:0] memAddr_Out;
    logic [DW-1:0] memWdata_Out, rdata_Out;
    logic          fetchStall_Out, memStall_Out;

    memory_port_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LATENCY    (LAT)
`ifdef MEM_ARB_STARVE_GUARD_EN
        ,
        .STARVE_LIMIT (SLIM)
`endif
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .fetchReq_In    (fetchReq_In),
        .fetchAddr_In   (fetchAddr_In),
        .memReq_In      (memReq_In),
        .memWrite_In    (memWrite_In),
        .memAddr_In     (memAddr_In),
        .memData_In     (memData_In),
        .memRdata_In    (memRdata_In),
        .memEnable_Out  (memEnable_Out),
        .memWe_Out      (memWe_Out),
        .memAddr_Out    (memAddr_Out),
        .memWdata_Out   (memWdata_Out),
        .fetchDone_Out  (fetchDone_Out),
        .memDone_Out    (memDone_Out),
        .rdata_Out      (rdata_Out),
        .fetchStall_Out (fetchStall_Out),
        .memStall_Out   (memStall_Out)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return DW'((32'(a) * 32'd40503) ^ 32'h5A5A5);
    endfunction

    // Memory macro: writes commit at the enable edge, reads appear LAT cycles after enable.
    logic [DW-1:0] phys_mem [logic [AW-1:0]];
    logic [DW-1:0] rd_pipe [LAT];

    function automatic logic [DW-1:0] phys_read(input logic [AW-1:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
    endfunction

    always @(posedge clock) begin
        for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= memEnable_Out ? phys_read(memAddr_Out) : '0;
        if (memEnable_Out && memWe_Out) phys_mem[memAddr_Out] = memWdata_Out;
    end
    assign memRdata_In = rd_pipe[LAT-1];

    // Reference model: one access at a time, granted in the first free cycle that
    // sees a request; enable one cycle later, done LAT+2 cycles after the grant.
    logic [DW-1:0] model_mem [logic [AW-1:0]];
    bit            busy = 1'b0;
    int            issue_cyc, done_cyc;
    bit            acc_mem, acc_we, pick_mem;
    logic [DW-1:0] acc_wdata, acc_rdata;
    logic [AW-1:0] last_addr = '0;
    int            starve_cnt = 0;
    int            en_count = 0, md_count = 0;
    bit            seen_fd = 1'b0, seen_md = 1'b0;
    bit            exp_en, exp_we, exp_fd, exp_md;

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_word(a);
    endfunction

    always @(negedge clock) begin
        if (!reset) begin
            check("rst_ctrl", 32'({memEnable_Out, memWe_Out, fetchDone_Out, memDone_Out}), 32'd0);
            check("rst_addr", 32'(memAddr_Out), 32'd0);
            check("rst_wdata", 32'(memWdata_Out), 32'd0);
            check("rst_rdata", 32'(rdata_Out), 32'd0);
            busy       = 1'b0;
            last_addr  = '0;
            starve_cnt = 0;
            seen_fd    = 1'b0;
            seen_md    = 1'b0;
        end else begin
            if (busy && cyc > done_cyc) busy = 1'b0;
            exp_en = busy && (cyc == issue_cyc);
            exp_we = exp_en && acc_we;
            exp_fd = busy && (cyc == done_cyc) && !acc_mem;
            exp_md = busy && (cyc == done_cyc) && acc_mem;
            check("enable", 32'(memEnable_Out), 32'(exp_en));
            check("write_en", 32'(memWe_Out), 32'(exp_we));
            check("fetch_done", 32'(fetchDone_Out), 32'(exp_fd));
            check("mem_done", 32'(memDone_Out), 32'(exp_md));
            check("addr", 32'(memAddr_Out), 32'(last_addr));
            if (exp_we) check("wdata", 32'(memWdata_Out), 32'(acc_wdata));
            if ((exp_fd || exp_md) && !acc_we) check("rdata", 32'(rdata_Out), 32'(acc_rdata));
            check("fetch_stall", 32'(fetchStall_Out), 32'(fetchReq_In && !exp_fd));
            check("mem_stall", 32'(memStall_Out), 32'(memReq_In && !exp_md));
            if (memEnable_Out) en_count++;
            if (memDone_Out) md_count++;
            seen_fd = fetchDone_Out;
            seen_md = memDone_Out;
            if (!busy && (fetchReq_In || memReq_In)) begin
                pick_mem = memReq_In;
`ifdef MEM_ARB_STARVE_GUARD_EN
                if (memReq_In && fetchReq_In && starve_cnt >= int'(SLIM)) pick_mem = 1'b0;
`endif
                if (!pick_mem) starve_cnt = 0;
                else if (fetchReq_In) starve_cnt++;
                busy      = 1'b1;
                issue_cyc = cyc + 1;
                done_cyc  = cyc + int'(LAT) + 2;
                acc_mem   = pick_mem;
                if (pick_mem) begin
                    last_addr = memAddr_In;
                    acc_we    = memWrite_In;
                    acc_wdata = memData_In;
                    if (memWrite_In) model_mem[memAddr_In] = memData_In;
                    else acc_rdata = model_read(memAddr_In);
                end else begin
                    last_addr = fetchAddr_In;
                    acc_we    = 1'b0;
                    acc_rdata = model_read(fetchAddr_In);
                end
            end
        end
    end

    task automatic wait_done(input bit is_mem, output int td, output logic [DW-1:0] rd);
        td = -1;
        rd = '0;
        for (int b = 0; b < 60; b++) begin
            @(negedge clock);
            if (is_mem ? memDone_Out : fetchDone_Out) begin
                td = cyc;
                rd = rdata_Out;
                break;
            end
        end
        if (td < 0) check(is_mem ? "mem_done_timeout" : "fetch_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic mem_access(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              output int lat, output logic [DW-1:0] rd);
        int t0, td;
        @(posedge clock); #1;
        memReq_In = 1'b1; memWrite_In = wr; memAddr_In = a; memData_In = d;
        t0 = cyc;
        wait_done(1'b1, td, rd);
        lat = td - t0;
        @(posedge clock); #1;
        memReq_In = 1'b0;
    endtask

    int            lat, t0, td, e0, md0, mb, fd_total;
    logic [DW-1:0] rd;
    bit            got_md, got_fd, fetch_seen;

    initial begin
        for (int i = 0; i < int'(LAT); i++) rd_pipe[i] = '0;
        phys_mem[16'h0010]  = 20'h12345;
        model_mem[16'h0010] = 20'h12345;
        reset = 1'b0;
        fetchReq_In = 1'b0; fetchAddr_In = '0;
        memReq_In = 1'b0; memWrite_In = 1'b0; memAddr_In = '0; memData_In = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        // Single load and single store with readback.
        mem_access(1'b0, 16'h0010, '0, lat, rd);
        check("load_latency", 32'(lat), 32'(LAT + 2));
        check("load_rdata", 32'(rd), 32'h12345);
        mem_access(1'b1, 16'h0020, 20'hABCDE, lat, rd);
        check("store_latency", 32'(lat), 32'(LAT + 2));
        mem_access(1'b0, 16'h0020, '0, lat, rd);
        check("store_readback", 32'(rd), 32'hABCDE);

        // Tie: memory stage first, fetch right after.
        @(posedge clock); #1;
        memReq_In = 1'b1; memWrite_In = 1'b0; memAddr_In = 16'h0005;
        fetchReq_In = 1'b1; fetchAddr_In = 16'h0100;
        t0 = cyc;
        wait_done(1'b1, td, rd);
        check("tie_mem_done", 32'(td - t0), 32'(LAT + 2));
        @(posedge clock); #1 memReq_In = 1'b0;
        wait_done(1'b0, td, rd);
        check("tie_fetch_done", 32'(td - t0), 32'(2 * (LAT + 2) + 1));
        check("tie_fetch_rdata", 32'(rd), 32'(init_word(16'h0100)));
        @(posedge clock); #1 fetchReq_In = 1'b0;

        // Back-to-back fetch with the request held across the done pulse.
        e0 = en_count;
        @(posedge clock); #1;
        fetchReq_In = 1'b1; fetchAddr_In = 16'h0000;
        wait_done(1'b0, td, rd);
        @(posedge clock); #1 fetchAddr_In = 16'h0001;
        t0 = cyc;
        wait_done(1'b0, td, rd);
        check("b2b_latency", 32'(td - t0), 32'(LAT + 2));
        check("b2b_rdata", 32'(rd), 32'(init_word(16'h0001)));
        @(posedge clock); #1 fetchReq_In = 1'b0;
        check("b2b_enables", 32'(en_count - e0), 32'd2);

        // Reset during WAIT abandons the access.
        @(posedge clock); #1;
        memReq_In = 1'b1; memWrite_In = 1'b0; memAddr_In = 16'h0033;
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b0; memReq_In = 1'b0;
        #1;
        check("rstmid_ctrl", 32'({memEnable_Out, memWe_Out, fetchDone_Out, memDone_Out}), 32'd0);
        check("rstmid_addr", 32'(memAddr_Out), 32'd0);
        check("rstmid_rdata", 32'(rdata_Out), 32'd0);
        md0 = md_count;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        repeat (LAT + 3) @(posedge clock);
        check("rstmid_no_done", 32'(md_count - md0), 32'd0);
        mem_access(1'b0, 16'h0010, '0, lat, rd);
        check("rstmid_restart_lat", 32'(lat), 32'(LAT + 2));
        check("rstmid_restart_rdata", 32'(rd), 32'h12345);

        // Both requesters continuously busy.
        @(posedge clock); #1;
        memReq_In = 1'b1; memWrite_In = 1'b0; memAddr_In = AW'($urandom_range(0, 31));
        fetchReq_In = 1'b1; fetchAddr_In = AW'($urandom_range(0, 31));
        mb = 0; fd_total = 0; fetch_seen = 1'b0;
        for (int n = 0; n < 8 * (int'(LAT) + 3); n++) begin
            @(negedge clock);
            got_md = memDone_Out;
            got_fd = fetchDone_Out;
            if (got_md && !fetch_seen) mb++;
            if (got_fd) begin fd_total++; fetch_seen = 1'b1; end
            @(posedge clock); #1;
            if (got_md) memAddr_In = AW'($urandom_range(0, 31));
            if (got_fd) fetchAddr_In = AW'($urandom_range(0, 31));
        end
`ifdef MEM_ARB_STARVE_GUARD_EN
        check("starve_mem_before_fetch", 32'(mb), 32'(SLIM));
        check("starve_fetch_wins", 32'(fd_total), 32'd1);
`else
        check("starve_fetch_wins", 32'(fd_total), 32'd0);
        check("starve_mem_wins", 32'(mb), 32'd8);
`endif
        memReq_In = 1'b0;
        wait_done(1'b0, td, rd);
        @(posedge clock); #1 fetchReq_In = 1'b0;

        // Random traffic: requests held until done, then dropped or re-targeted.
        for (int n = 0; n < 2500; n++) begin
            @(posedge clock); #1;
            if (memReq_In) begin
                if (seen_md) begin
                    if ($urandom_range(0, 2) == 0) memReq_In = 1'b0;
                    else begin
                        memWrite_In = 1'($urandom_range(0, 1));
                        memAddr_In  = AW'($urandom_range(0, 31));
                        memData_In  = DW'($urandom);
                    end
                end
            end else if ($urandom_range(0, 3) == 0) begin
                memReq_In   = 1'b1;
                memWrite_In = 1'($urandom_range(0, 1));
                memAddr_In  = AW'($urandom_range(0, 31));
                memData_In  = DW'($urandom);
            end
            if (fetchReq_In) begin
                if (seen_fd) begin
                    if ($urandom_range(0, 2) == 0) fetchReq_In = 1'b0;
                    else fetchAddr_In = AW'($urandom_range(0, 31));
                end
            end else if ($urandom_range(0, 3) == 0) begin
                fetchReq_In  = 1'b1;
                fetchAddr_In = AW'($urandom_range(0, 31));
            end
        end

        // Drain: release each request only after its done pulse.
        for (int n = 0; n < 100 && (memReq_In || fetchReq_In); n++) begin
            @(posedge clock); #1;
            if (memReq_In && seen_md) memReq_In = 1'b0;
            if (fetchReq_In && seen_fd) fetchReq_In = 1'b0;
        end
        check("drain_idle", 32'({memReq_In, fetchReq_In}), 32'd0);
        repeat (5) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_port_arbiter.md
Name: memory_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between two requesters: the instruction-fetch stage (read only) and the memory-access stage (read or write).
- Sequences each access with a fixed memory read latency, returns read data and a one-cycle done pulse to the winning requester, and stalls the losing or waiting stage.
- Sits between the pipeline stages and the memory macro. The memory-access stage's write-enable decode (STORE) feeds memWrite_In.

Parameters:
ADDR_WIDTH, 16, memory address width
DATA_WIDTH, 20, memory word width (instruction and data words)
LATENCY, 2, cycles from enable cycle to read data valid; legal range is 1 or more
STARVE_LIMIT, 4, consecutive lost arbitrations before fetch is forced to win (optional feature only)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
fetchReq_In  in  1  fetch request; held until fetchDone_Out
fetchAddr_In  in  ADDR_WIDTH  fetch address; stable while request is held
memReq_In  in  1  memory-access stage request; held until memDone_Out
memWrite_In  in  1  1 = store, 0 = load
memAddr_In  in  ADDR_WIDTH  load/store address
memData_In  in  DATA_WIDTH  store data
memRdata_In  in  DATA_WIDTH  memory read data
memEnable_Out  out  1  memory access strobe
memWe_Out  out  1  memory write enable
memAddr_Out  out  ADDR_WIDTH  memory address
memWdata_Out  out  DATA_WIDTH  memory write data
fetchDone_Out  out  1  one-cycle completion pulse to fetch
memDone_Out  out  1  one-cycle completion pulse to the memory-access stage
rdata_Out  out  DATA_WIDTH  read data; valid when either done pulse is high
fetchStall_Out  out  1  fetchReq_In and not fetchDone_Out
memStall_Out  out  1  memReq_In and not memDone_Out

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered except the two stall outputs, which are combinational.
- Reset (asynchronous, reset=0): state goes to IDLE; all enables, write enable and done pulses go to 0; memAddr_Out, memWdata_Out and rdata_Out go to 0; the wait counter and starvation counter clear.
- IDLE: if any request is present, choose a winner and latch the winner ID, address, write flag and write data, then go to ISSUE. The memory-access stage wins ties. No request means stay in IDLE.
- ISSUE (exactly 1 cycle): memEnable_Out=1; memWe_Out=1 only for a memory-stage store; load counter with LATENCY-1; go to WAIT.
- WAIT (LATENCY cycles): counter decrements. When counter is 0, capture memRdata_In into rdata_Out (stores also capture; the value is don't-care) and go to RESP.
- RESP (1 cycle): assert the winner's done pulse; go to IDLE.
- Timing: a request seen in IDLE at cycle T produces done at cycle T+LATENCY+2. Minimum issue spacing is LATENCY+3 cycles.
- The requester drops or changes its request at the edge ending the RESP cycle. Because RESP never grants, a request still high in the done cycle is not double-serviced.
- memEnable_Out and memWe_Out are high only in ISSUE. Address and write data stay held from ISSUE through RESP.
- Requests that rise during ISSUE, WAIT or RESP wait, stalled, until the next IDLE.
- A request that drops before being granted is ignored. Dropping a request after grant is illegal; the access still completes and the done pulse is still issued.
- Reset mid-access: the in-flight access is abandoned and no done pulse is issued. A store already issued in ISSUE may have committed to memory.
- Fetch starves under continuous memory-stage traffic unless MEM_ARB_STARVE_GUARD_EN is defined.

Optional Feature:
- Macro MEM_ARB_STARVE_GUARD_EN.
- Defined: a 3-bit (or wider) counter increments on each IDLE decision where both requesters are present and the memory stage wins. When it reaches STARVE_LIMIT, the next tied decision goes to fetch and the counter clears. The counter also clears whenever fetch wins.
- Undefined: strict memory-stage priority, and no counter exists.

Decomposition:
- Shared package holds:
  - opcode constants (STORE 4'b1100, COPY_INPUT 4'b1111)
  - FSM state encoding (2 bits)
  - requester ID constants (REQ_FETCH, REQ_MEM)
  - LATENCY legality check
- One natural sub-module, arb_grant_select: combinational winner selection from the two requests plus the starvation flag.

Test Plan:
- Single load: memReq=1, memWrite=0, addr 0x0010, memory returns 0x12345 two cycles after enable. Expect memEnable high for 1 cycle with addr 0x0010, memDone at T+4, rdata_Out=0x12345, memStall high T..T+3.
- Single store: addr 0x0020, data 0xABCDE. Expect memEnable=memWe=1 in the ISSUE cycle only, memWdata_Out=0xABCDE, memDone at T+4, fetchDone never asserts.
- Tie: fetchReq and memReq rise together. Expect memory access first (done T+4), then fetch issues the cycle after IDLE is re-entered and completes at T+9, stalled until then.
- Back-to-back fetch: fetchReq held, address changed to 0x0001 immediately after done. Expect exactly one access per done pulse and no duplicate enable for the old address.
- Reset at the WAIT cycle: reset=0 pulse. Expect all outputs 0 immediately, no done pulse, restart from IDLE with a new request.
- MEM_ARB_STARVE_GUARD_EN defined, STARVE_LIMIT=4, both requests always high: fetch wins on the 5th decision; without the macro fetch never wins.
